// File: rtl/uart_rx_pkg.sv
// Shared constants and the majority-vote helper for the UART receive path.
package uart_rx_pkg;

  localparam int   PRESCALE_MIN = 6;
  localparam int   BIT_CNT_W    = 4;
  localparam logic IDLE_LEVEL   = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_rx_sync
  import uart_rx_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q <= {STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX oversampling stage: edge/bit counters and a 3-point majority vote around bit centre.
// Defining UART_RX_NOISE_DETECT_EN adds the Noise output (vote not unanimous).
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  Rx_In,
  input  logic                  Sample_En,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  Rx_Sync,
  output logic [PRESCALE_W-1:0] Edge_Cnt,
  output logic [BIT_CNT_W-1:0]  Bit_Cnt,
  output logic                  Bit_Done,
  output logic                  Center_Sample,
  output logic                  Valid
`ifdef UART_RX_NOISE_DETECT_EN
  ,
  output logic                  Noise
`endif
);

  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(PRESCALE_MIN);
  localparam logic [PRESCALE_W-1:0] ONE   = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] p_eff;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last_edge;
  logic                  at_s0;
  logic                  at_s1;
  logic                  at_vote;
  logic                  wrap;
  logic                  s0;
  logic                  s1;
  logic                  valid_q;
  logic                  vote;

  uart_rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK  (CLK),
    .RSTn (RSTn),
    .din  (Rx_In),
    .dout (Rx_Sync)
  );

  // Short prescales are clamped so the three sample points and the vote always fit in one bit.
  assign p_eff     = (Prescale < P_MIN) ? P_MIN : Prescale;
  assign half      = p_eff >> 1;
  assign last_edge = p_eff - ONE;

  assign at_s0   = (Edge_Cnt == half - ONE);
  assign at_s1   = (Edge_Cnt == half);
  assign at_vote = (Edge_Cnt == half + ONE);
  assign wrap    = (Edge_Cnt >= last_edge);
  assign vote    = maj3(s0, s1, Rx_Sync);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Edge_Cnt <= '0;
      Bit_Cnt  <= '0;
    end else if (!Sample_En) begin
      Edge_Cnt <= '0;
      Bit_Cnt  <= '0;
    end else if (wrap) begin
      Edge_Cnt <= '0;
      Bit_Cnt  <= Bit_Cnt + BIT_CNT_W'(1);
    end else begin
      Edge_Cnt <= Edge_Cnt + ONE;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s0            <= IDLE_LEVEL;
      s1            <= IDLE_LEVEL;
      Center_Sample <= IDLE_LEVEL;
      valid_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!Sample_En) begin
        s0 <= IDLE_LEVEL;
        s1 <= IDLE_LEVEL;
      end else begin
        if (at_s0) s0 <= Rx_Sync;
        if (at_s1) s1 <= Rx_Sync;
        if (at_vote) begin
          Center_Sample <= vote;
          valid_q       <= 1'b1;
        end
      end
    end
  end

  // Gating with Sample_En drops a Valid that was pending when the FSM disabled the block.
  assign Valid    = valid_q & Sample_En;
  assign Bit_Done = Sample_En & (Edge_Cnt == last_edge);

`ifdef UART_RX_NOISE_DETECT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Noise <= 1'b0;
    end else begin
      Noise <= Sample_En & at_vote & !((s0 == s1) && (s1 == Rx_Sync));
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: per-cycle model built from counts of enabled edges.
module tb_uart_rx_sampler;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       Rx_In;
  logic       Sample_En;
  logic [5:0] Prescale;
  logic       Rx_Sync;
  logic [5:0] Edge_Cnt;
  logic [3:0] Bit_Cnt;
  logic       Bit_Done;
  logic       Center_Sample;
  logic       Valid;
`ifdef UART_RX_NOISE_DETECT_EN
  logic       Noise;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  int   k;
  int   p_cur;
  logic exp_center;
  logic rx_hist [0:8191];

  always #5 CLK = ~CLK;

  uart_rx_sampler #(
    .PRESCALE_W  (6),
    .SYNC_STAGES (2)
  ) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .Rx_In         (Rx_In),
    .Sample_En     (Sample_En),
    .Prescale      (Prescale),
    .Rx_Sync       (Rx_Sync),
    .Edge_Cnt      (Edge_Cnt),
    .Bit_Cnt       (Bit_Cnt),
    .Bit_Done      (Bit_Done),
    .Center_Sample (Center_Sample),
    .Valid         (Valid)
`ifdef UART_RX_NOISE_DETECT_EN
    ,
    .Noise         (Noise)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int eff_p(input int presc);
    return (presc < 6) ? 6 : presc;
  endfunction

  // k = consecutive enabled edges; everything expected follows from k, P and the line history.
  task automatic check_cycle();
    int   h;
    int   ecnt;
    int   ones;
    logic ev;
    h    = p_cur / 2;
    ecnt = k % p_cur;
    ev   = (k > 0) && (ecnt == h + 2);
    ones = 0;
    if (ev) begin
      ones = int'(rx_hist[cyc-4]) + int'(rx_hist[cyc-3]) + int'(rx_hist[cyc-2]);
      exp_center = (ones >= 2);
    end
    chk("rx_sync",  32'(Rx_Sync),       32'(rx_hist[cyc-1]));
    chk("edge_cnt", 32'(Edge_Cnt),      32'(ecnt));
    chk("bit_cnt",  32'(Bit_Cnt),       32'((k / p_cur) % 16));
    chk("bit_done", 32'(Bit_Done),      32'((k > 0) && (ecnt == p_cur - 1)));
    chk("valid",    32'(Valid),         32'(ev));
    chk("center",   32'(Center_Sample), 32'(exp_center));
`ifdef UART_RX_NOISE_DETECT_EN
    chk("noise",    32'(Noise),         32'(ev && (ones == 1 || ones == 2)));
`endif
  endtask

  task automatic step(input logic rx, input logic en);
    Rx_In     = rx;
    Sample_En = en;
    @(posedge CLK);
    cyc++;
    if (cyc >= 8191) begin
      $display("FAIL cycle_budget: observed %0d cycles, limit 8190", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    rx_hist[cyc] = rx;
    k = en ? k + 1 : 0;
    #1;
    check_cycle();
  endtask

  task automatic reset_and_check();
    RSTn = 1'b0;
    #1;
    chk("rst_rx_sync",  32'(Rx_Sync),       32'(1));
    chk("rst_edge_cnt", 32'(Edge_Cnt),      32'(0));
    chk("rst_bit_cnt",  32'(Bit_Cnt),       32'(0));
    chk("rst_bit_done", 32'(Bit_Done),      32'(0));
    chk("rst_center",   32'(Center_Sample), 32'(1));
    chk("rst_valid",    32'(Valid),         32'(0));
`ifdef UART_RX_NOISE_DETECT_EN
    chk("rst_noise",    32'(Noise),         32'(0));
`endif
    Sample_En = 1'b0;
    Rx_In     = 1'b1;
    repeat (3) @(posedge CLK);
    #3;
    RSTn = 1'b1;
    rx_hist[cyc] = 1'b1;
    k = 0;
    exp_center = 1'b1;
  endtask

  // Line leads the enable by two edges so each bit lines up with the synchroniser delay.
  task automatic run_frame(input int presc, input logic [31:0] bits, input int nbits,
                           input int glitch_s);
    logic ln;
    Prescale = 6'(presc);
    p_cur    = eff_p(presc);
    for (int s = 0; s <= nbits * p_cur + 1; s++) begin
      ln = (s < nbits * p_cur) ? bits[s / p_cur] : 1'b1;
      if (s == glitch_s) ln = ~ln;
      step(ln, s >= 2);
    end
    step(1'b1, 1'b0);
  endtask

  initial begin
    int   presc;
    int   nb;
    logic [31:0] pat;
    RSTn      = 1'b1;
    Rx_In     = 1'b1;
    Sample_En = 1'b0;
    Prescale  = 6'd8;
    p_cur     = 8;
    cyc       = 0;
    k         = 0;
    exp_center = 1'b1;
    for (int i = 0; i < 8192; i++) rx_hist[i] = 1'b1;

    #2;
    reset_and_check();

    // Single zero bit at P=8.
    run_frame(8, 32'h0000_0002, 2, -1);

    // One-cycle low glitch on the centre sample of a high bit.
    run_frame(8, 32'h0000_0003, 2, 4);

    // Ten-bit pattern at P=16.
    run_frame(16, 32'h0000_029A, 10, -1);

    // Prescale below the minimum behaves as six.
    run_frame(3, 32'h0000_0005, 4, -1);

    // Enable dropped at Edge_Cnt==3, then re-enabled.
    Prescale = 6'd8;
    p_cur    = 8;
    step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b1);
    step(1'b1, 1'b0);

    // Asynchronous reset in the middle of the second bit.
    repeat (12) step(1'b0, 1'b1);
    #2;
    reset_and_check();
    step(1'b1, 1'b0);

    // Long run for the 4-bit bit counter wrap.
    run_frame(6, 32'h0002_A5C3, 18, -1);

    // Random prescales, patterns and glitches.
    for (int r = 0; r < 10; r++) begin
      presc = $urandom_range(0, 24);
      nb    = $urandom_range(3, 12);
      pat   = $urandom;
      run_frame(presc, pat, nb, $urandom_range(0, 3) == 0 ? -1 :
                $urandom_range(0, nb * eff_p(presc)));
      repeat ($urandom_range(0, 3)) step(1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
